// File: rtl/shadow_reg_ctrl.sv
// Two-phase shadowed control register: a value commits only after two identical
// consecutive writes, and the committed copy is guarded by an inverted shadow.
module shadow_reg_ctrl #(
    parameter int            DW     = 5,
    parameter logic [DW-1:0] RESVAL = 5'b11000
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          we_i,
    input  logic [DW-1:0] wd_i,
    input  logic          re_i,
    output logic [DW-1:0] q_o,
    output logic          qe_o,
    output logic          phase_o,
    output logic          err_update_o,
    output logic          err_storage_o
);

    typedef enum logic {
        IDLE   = 1'b0,
        STAGED = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] staged_q, staged_d;
    logic [DW-1:0] committed_q;
    logic [DW-1:0] shadow_q;
    logic          qe_q;
    logic          err_update_q;
    logic          err_storage_q;
    logic          commit;
    logic          mismatch;
    logic          storage_bad;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A write while STAGED always ends the sequence; only a matching one may
    // commit, and never once the storage copies have been found inconsistent.
    always_comb begin
        state_d  = state_q;
        staged_d = staged_q;
        commit   = 1'b0;
        mismatch = 1'b0;
        case (state_q)
            IDLE: begin
                if (we_i) begin
                    staged_d = wd_i;
                    state_d  = STAGED;
                end
            end
            STAGED: begin
                if (we_i) begin
                    state_d = IDLE;
                    if (wd_i == staged_q) begin
                        commit = ~err_storage_q;
                    end else begin
                        mismatch = 1'b1;
                    end
                end else if (re_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign storage_bad = (committed_q != ~shadow_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            staged_q      <= RESVAL;
            committed_q   <= RESVAL;
            shadow_q      <= ~RESVAL;
            qe_q          <= 1'b0;
            err_update_q  <= 1'b0;
            err_storage_q <= 1'b0;
        end else begin
            staged_q      <= staged_d;
            qe_q          <= commit;
            err_update_q  <= mismatch;
            err_storage_q <= err_storage_q | storage_bad;
            if (commit) begin
                committed_q <= wd_i;
                shadow_q    <= ~wd_i;
            end
        end
    end

    assign q_o           = committed_q;
    assign qe_o          = qe_q;
    assign phase_o       = (state_q == STAGED);
    assign err_update_o  = err_update_q;
    assign err_storage_o = err_storage_q;

endmodule

// File: tb/tb_shadow_reg_ctrl.sv
// Self-checking bench for shadow_reg_ctrl: directed scenarios plus randomized
// write/read traffic compared against a behavioural two-write commit model.
module tb_shadow_reg_ctrl;

    localparam int         DW     = 5;
    localparam logic [4:0] RESVAL = 5'b11000;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          we_i;
    logic [DW-1:0] wd_i;
    logic          re_i;
    logic [DW-1:0] q_o;
    logic          qe_o;
    logic          phase_o;
    logic          err_update_o;
    logic          err_storage_o;

    int checkCount = 0;
    int passCount  = 0;

    // Reference model state, expressed in terms of the register's visible behaviour
    bit         mPending;
    bit         mLocked;
    logic [4:0] mStaged;
    logic [4:0] mQ;
    bit         mQe;
    bit         mErrUpd;

    shadow_reg_ctrl #(.DW(DW), .RESVAL(RESVAL)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .we_i          (we_i),
        .wd_i          (wd_i),
        .re_i          (re_i),
        .q_o           (q_o),
        .qe_o          (qe_o),
        .phase_o       (phase_o),
        .err_update_o  (err_update_o),
        .err_storage_o (err_storage_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        mPending = 0;
        mLocked  = 0;
        mStaged  = RESVAL;
        mQ       = RESVAL;
        mQe      = 0;
        mErrUpd  = 0;
    endtask

    task automatic modelStep(input bit we, input logic [4:0] wd, input bit re);
        mQe     = 0;
        mErrUpd = 0;
        if (!mPending) begin
            if (we) begin
                mStaged  = wd;
                mPending = 1;
            end
        end else if (we) begin
            mPending = 0;
            if (wd != mStaged) begin
                mErrUpd = 1;
            end else if (!mLocked) begin
                mQ  = wd;
                mQe = 1;
            end
        end else if (re) begin
            mPending = 0;
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".q"}, 32'(q_o), 32'(mQ));
        checkOutput({tag, ".qe"}, 32'(qe_o), 32'(mQe));
        checkOutput({tag, ".phase"}, 32'(phase_o), 32'(mPending));
        checkOutput({tag, ".errUpd"}, 32'(err_update_o), 32'(mErrUpd));
        checkOutput({tag, ".errSto"}, 32'(err_storage_o), 32'(mLocked));
    endtask

    task automatic applyStimulus(input string tag, input bit we, input logic [4:0] wd, input bit re);
        we_i = we;
        wd_i = wd;
        re_i = re;
        @(posedge clk_i);
        modelStep(we, wd, re);
        #1;
        checkAll(tag);
    endtask

    initial begin
        logic [4:0] rwd;
        bit         rwe;
        bit         rre;

        rst_ni = 1'b0;
        we_i   = 1'b0;
        wd_i   = '0;
        re_i   = 1'b0;
        modelReset();
        #12;
        checkAll("reset");
        @(negedge clk_i);
        rst_ni = 1'b1;

        for (int i = 0; i < 3; i++) applyStimulus("idle", 0, 5'h00, 0);

        applyStimulus("pair1a", 1, 5'h07, 0);
        applyStimulus("pair1b", 1, 5'h07, 0);
        applyStimulus("pair1c", 0, 5'h00, 0);

        applyStimulus("mis1a", 1, 5'h07, 0);
        applyStimulus("mis1b", 1, 5'h03, 0);
        applyStimulus("mis1c", 0, 5'h00, 0);

        applyStimulus("abort1", 1, 5'h0A, 0);
        applyStimulus("abort2", 0, 5'h00, 1);
        applyStimulus("abort3", 1, 5'h0A, 0);
        applyStimulus("abort4", 1, 5'h0A, 0);

        applyStimulus("same1", 1, 5'h0A, 0);
        applyStimulus("same2", 1, 5'h0A, 1);

        for (int i = 0; i < 400; i++) begin
            rwe = ($urandom_range(0, 2) != 0);
            rre = ($urandom_range(0, 3) == 0);
            rwd = 5'($urandom);
            if (mPending && $urandom_range(0, 1) == 1) rwd = mStaged;
            applyStimulus("rand", rwe, rwd, rre);
        end

        applyStimulus("preForce", 0, 5'h00, 1);
        force dut.shadow_q = dut.committed_q;
        mLocked = 1;
        applyStimulus("force", 0, 5'h00, 0);
        release dut.shadow_q;
        applyStimulus("lockA", 1, 5'h1F, 0);
        applyStimulus("lockB", 1, 5'h1F, 0);
        applyStimulus("lockMisA", 1, 5'h02, 0);
        applyStimulus("lockMisB", 1, 5'h03, 0);
        applyStimulus("lockHold", 0, 5'h00, 0);

        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        modelReset();
        checkAll("lockReset");
        @(negedge clk_i);
        rst_ni = 1'b1;

        applyStimulus("stageA", 1, 5'h05, 0);
        #3;
        rst_ni = 1'b0;
        #1;
        modelReset();
        checkAll("midReset");
        @(negedge clk_i);
        rst_ni = 1'b1;
        applyStimulus("post1", 1, 5'h01, 0);
        applyStimulus("post2", 0, 5'h00, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/shadow_reg_ctrl.md
# shadow_reg_ctrl

Two-phase shadowed control register holding a packed 5-bit control word (`{a[1:0], b[2:0]}`) that feeds the parameterised sub-register stage through its `RESVAL`/value path. A new value takes effect only after two identical consecutive writes. The committed value is held together with an inverted shadow copy, and update and storage integrity errors are flagged. It sits between the register write interface and the consumers of the control field.

## Interface
Parameters:
- `DW`, 5, width of the control word (`a` in [4:3], `b` in [2:0])
- `RESVAL`, `5'b11000` (a='1, b='0, value 24), reset value of staged and committed copies

Ports:
- `clk_i`  input  1  clock
- `rst_ni`  input  1  reset; asynchronous, active-low
- `we_i`  input  1  write strobe, one write per cycle when high
- `wd_i`  input  DW  write data, sampled when `we_i`=1
- `re_i`  input  1  read strobe; aborts a pending first phase
- `q_o`  output  DW  committed value (registered)
- `qe_o`  output  1  one-cycle pulse, coincident with `q_o` changing on commit
- `phase_o`  output  1  0 = IDLE (expect first write), 1 = STAGED (expect confirming write)
- `err_update_o`  output  1  one-cycle pulse when the second write mismatches the staged value
- `err_storage_o`  output  1  sticky flag: committed copy and shadow copy disagree

## Operation
- Internal state: `staged[DW]`, `committed[DW]` (drives `q_o`), `shadow[DW]` (holds ~committed), FSM {IDLE, STAGED}, `lock` (= `err_storage_o`).
- Reset values: staged=RESVAL, committed=q_o=RESVAL, shadow=~RESVAL, FSM=IDLE, `phase_o`=0, `qe_o`=0, `err_update_o`=0, `err_storage_o`=0.
- IDLE, `we_i`=1: staged <= wd_i; move to STAGED.
- IDLE, `we_i`=0: hold state.
- STAGED, `we_i`=1, wd_i == staged, lock=0: committed <= wd_i, shadow <= ~wd_i, `qe_o` pulses; move to IDLE.
- STAGED, `we_i`=1, wd_i != staged: no commit, `err_update_o` pulses; move to IDLE. `staged` keeps the first-phase value.
- STAGED, `we_i`=1, match, lock=1: no commit, no `qe_o`; move to IDLE.
- STAGED, `re_i`=1, `we_i`=0: abort to IDLE. No error, no commit.
- `we_i` and `re_i` both high: the write takes precedence and `re_i` is ignored.
- Storage check (continuous): if committed != ~shadow, set `err_storage_o` on the next edge. It stays high until `rst_ni` is asserted.
- While `err_storage_o`=1: `q_o` is frozen and all commits are blocked. The FSM still steps and `err_update_o` still reports mismatches.
- Rewriting an identical value still commits and pulses `qe_o`.

## Timing
- Commit latency: second matching write sampled at edge N → `q_o`/`qe_o` valid after edge N, i.e. in cycle N+1.
- `qe_o` is exactly one cycle wide. Back-to-back pairs can commit every 2 cycles.
- `err_update_o` is asserted in the cycle after the mismatching write, for exactly one cycle.
- `phase_o` reflects the registered FSM state: 1 from the cycle after the first write until the cycle after the second write or abort.
- `err_storage_o` is asserted one edge after the mismatch appears.
- Async reset mid-sequence (including while STAGED) immediately forces all outputs to their reset values. The pending phase is discarded.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then hold idle 3 cycles → `q_o`=24, `phase_o`=0, `qe_o`/`err_update_o`/`err_storage_o`=0.
- Write 5'h07 then 5'h07 on consecutive cycles → `phase_o`=1 for one cycle; `q_o`=7 with `qe_o`=1 for one cycle after the 2nd write; no errors.
- Write 5'h07 then 5'h03 → `err_update_o` pulses once; `q_o` stays 24; `phase_o` returns to 0.
- Write 5'h0A, then `re_i`=1 alone, then write 5'h0A once → no commit (`q_o`=24, `phase_o`=1). A further 5'h0A → `q_o`=10.
- Force `shadow` to equal committed for one cycle → `err_storage_o`=1 and stays 1. A subsequent matching pair 5'h1F/5'h1F gives no `qe_o` and `q_o` unchanged. `rst_ni` low clears the flag and `q_o` returns to 24.
- Assert `rst_ni`=0 asynchronously mid-cycle while STAGED → `phase_o`=0 and `q_o`=24 immediately. After release, a single write of 5'h01 does not commit.
